act_c2_func_mapper: RTL and testbench

//  Inverse of the ACT-2 C2 mux cell (S0=A0&B0, S1=A1|B1, out=D{S0,S1}): given a 4-var

---
 rtl/act_c2_map_pkg.sv | 43 ++++
 rtl/act_c2_slot_check.sv | 27 ++
 rtl/act_c2_func_mapper.sv | 91 +++++++++
 tb/tb_act_c2_func_mapper.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/act_c2_map_pkg.sv
// act_c2_map_pkg: source codes, state encoding and the source evaluator for the C2 mapper.
// ACT_C2_MAP_INV_EN adds the inverted-variable source codes 6..9.
package act_c2_map_pkg;
    localparam int SRC_W = 4;
    localparam logic [SRC_W-1:0] SRC_C0  = 4'd0;
    localparam logic [SRC_W-1:0] SRC_C1  = 4'd1;
    localparam logic [SRC_W-1:0] SRC_X0  = 4'd2;
    localparam logic [SRC_W-1:0] SRC_X1  = 4'd3;
    localparam logic [SRC_W-1:0] SRC_X2  = 4'd4;
    localparam logic [SRC_W-1:0] SRC_X3  = 4'd5;
    localparam logic [SRC_W-1:0] SRC_NX0 = 4'd6;
    localparam logic [SRC_W-1:0] SRC_NX1 = 4'd7;
    localparam logic [SRC_W-1:0] SRC_NX2 = 4'd8;
    localparam logic [SRC_W-1:0] SRC_NX3 = 4'd9;
`ifdef ACT_C2_MAP_INV_EN
    localparam int NSRC = 10;
`else
    localparam int NSRC = 6;
`endif
    localparam logic [1:0] SLOT_D00 = 2'd0;
    localparam logic [1:0] SLOT_D01 = 2'd1;
    localparam logic [1:0] SLOT_D10 = 2'd2;
    localparam logic [1:0] SLOT_D11 = 2'd3;

    typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

    function automatic logic src_val(input logic [SRC_W-1:0] src, input logic [3:0] x);
        case (src)
            SRC_C1:  src_val = 1'b1;
            SRC_X0:  src_val = x[0];
            SRC_X1:  src_val = x[1];
            SRC_X2:  src_val = x[2];
            SRC_X3:  src_val = x[3];
`ifdef ACT_C2_MAP_INV_EN
            SRC_NX0: src_val = ~x[0];
            SRC_NX1: src_val = ~x[1];
            SRC_NX2: src_val = ~x[2];
            SRC_NX3: src_val = ~x[3];
`endif
            default: src_val = 1'b0;
        endcase
    endfunction
endpackage

// File: rtl/act_c2_slot_check.sv
// act_c2_slot_check: tests one (slot, source) candidate against all 16 minterms at once.
// Source range depends on ACT_C2_MAP_INV_EN through the package evaluator.
module act_c2_slot_check
    import act_c2_map_pkg::*;
(
    input  logic [15:0]      truth_table,
    input  logic [1:0]       a1_sel,
    input  logic [1:0]       b1_sel,
    input  logic [1:0]       a0_sel,
    input  logic [1:0]       b0_sel,
    input  logic [1:0]       slot,
    input  logic [SRC_W-1:0] src,
    output logic             match
);
    logic [15:0] ok;

    // Minterms outside the slot's region are don't-cares, so an empty region matches anything.
    for (genvar m = 0; m < 16; m++) begin : g_m
        localparam logic [3:0] X = 4'(m);
        logic s0, s1;
        assign s0 = X[a0_sel] & X[b0_sel];
        assign s1 = X[a1_sel] | X[b1_sel];
        assign ok[m] = ({s0, s1} != slot) || (src_val(src, X) == truth_table[m]);
    end

    assign match = &ok;
endmodule

// File: rtl/act_c2_func_mapper.sv
// act_c2_func_mapper: sequential search for D-input sources of an ACT-2 C2 cell.
// ACT_C2_MAP_INV_EN widens the source set to include inverted variables.
module act_c2_func_mapper
    import act_c2_map_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [15:0]      truth_table,
    input  logic [1:0]       a1_sel,
    input  logic [1:0]       b1_sel,
    input  logic [1:0]       a0_sel,
    input  logic [1:0]       b0_sel,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic [SRC_W-1:0] d00_src,
    output logic [SRC_W-1:0] d01_src,
    output logic [SRC_W-1:0] d10_src,
    output logic [SRC_W-1:0] d11_src
);
    state_t           state, state_n;
    logic [15:0]      tt_q;
    logic [7:0]       sel_q;
    logic [1:0]       slot;
    logic [SRC_W-1:0] src;
    logic [SRC_W-1:0] d_src [4];
    logic             match;
    logic             last_src;
    logic             accept;

    act_c2_slot_check u_check (
        .truth_table(tt_q),
        .a1_sel     (sel_q[7:6]),
        .b1_sel     (sel_q[5:4]),
        .a0_sel     (sel_q[3:2]),
        .b0_sel     (sel_q[1:0]),
        .slot       (slot),
        .src        (src),
        .match      (match)
    );

    assign last_src = src == SRC_W'(NSRC - 1);
    assign accept   = start && state != SEARCH;
    assign busy     = state == SEARCH;
    assign done     = state == DONE;
    assign d00_src  = d_src[SLOT_D00];
    assign d01_src  = d_src[SLOT_D01];
    assign d10_src  = d_src[SLOT_D10];
    assign d11_src  = d_src[SLOT_D11];

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (state != SEARCH)
            state_n = start ? SEARCH : IDLE;
        else if ((match && slot == SLOT_D11) || (!match && last_src))
            state_n = DONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tt_q  <= '0;
            sel_q <= '0;
            slot  <= '0;
            src   <= '0;
            found <= 1'b0;
            for (int i = 0; i < 4; i++) d_src[i] <= '0;
        end else if (accept) begin
            tt_q  <= truth_table;
            sel_q <= {a1_sel, b1_sel, a0_sel, b0_sel};
            slot  <= '0;
            src   <= '0;
            found <= 1'b0;
            for (int i = 0; i < 4; i++) d_src[i] <= '0;
        end else if (state == SEARCH) begin
            if (match) begin
                d_src[slot] <= src;
                found       <= slot == SLOT_D11;
                slot        <= slot + 2'd1;
                src         <= '0;
            end else if (!last_src) begin
                src <= src + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_act_c2_func_mapper.sv
// tb_act_c2_func_mapper: directed checks of the C2 function mapper (both macro settings).
module tb_act_c2_func_mapper;
    logic        clk = 0;
    logic        rst = 1;
    logic        start = 0;
    logic [15:0] truth_table = '0;
    logic [1:0]  a1_sel = 2'd2, b1_sel = 2'd3, a0_sel = 2'd0, b0_sel = 2'd1;
    logic        busy, done, found;
    logic [3:0]  d00_src, d01_src, d10_src, d11_src;
    int          checks = 0;
    int          passes = 0;

    act_c2_func_mapper dut (
        .clk(clk), .rst(rst), .start(start), .truth_table(truth_table),
        .a1_sel(a1_sel), .b1_sel(b1_sel), .a0_sel(a0_sel), .b0_sel(b0_sel),
        .busy(busy), .done(done), .found(found),
        .d00_src(d00_src), .d01_src(d01_src), .d10_src(d10_src), .d11_src(d11_src)
    );

    always #5 clk = ~clk;

    // Pulses start and returns the number of edges until done, or -1 on timeout.
    task automatic launch(input logic [15:0] tt, output int cyc);
        truth_table = tt;
        start = 1;
        @(posedge clk); #1;
        start = 0;
        cyc = -1;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk); #1;
            if (done) begin
                cyc = i;
                break;
            end
        end
    endtask

    function automatic logic [16:0] res();
        return {found, d00_src, d01_src, d10_src, d11_src};
    endfunction

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1 rst = 0;
        checks++;
        if ({busy, done, res()} !== 19'd0) $display("FAIL reset: got %h want 0", {busy, done, res()});
        else passes++;
    endtask

    task automatic test_case(input string name, input logic [15:0] tt, input logic [16:0] exp_res, input int exp_cyc);
        int cyc;
        launch(tt, cyc);
        checks++;
        if (cyc !== exp_cyc) $display("FAIL %s latency: got %0d want %0d", name, cyc, exp_cyc);
        else passes++;
        checks++;
        if (res() !== exp_res) $display("FAIL %s result: got %h want %h", name, res(), exp_res);
        else passes++;
        checks++;
        if (busy !== 1'b0) $display("FAIL %s busy at done: got %b want 0", name, busy);
        else passes++;
        @(posedge clk); #1;
        checks++;
        if ({done, res()} !== {1'b0, exp_res}) $display("FAIL %s hold: got %h want %h", name, {done, res()}, {1'b0, exp_res});
        else passes++;
    endtask

    task automatic test_start_ignored();
        int cyc = -1;
        truth_table = 16'hFF00;
        start = 1;
        @(posedge clk); #1;
        start = 0;
        repeat (2) @(posedge clk);
        #1 truth_table = 16'h0000;
        a0_sel = 2'd3;
        start = 1;
        @(posedge clk); #1;
        start = 0;
        for (int i = 4; i <= 100; i++) begin
            @(posedge clk); #1;
            if (done) begin
                cyc = i;
                break;
            end
        end
        a0_sel = 2'd0;
        checks++;
        if (cyc !== 14) $display("FAIL start_ignored latency: got %0d want 14", cyc);
        else passes++;
        checks++;
        if (res() !== {1'b1, 4'd0, 4'd5, 4'd0, 4'd5}) $display("FAIL start_ignored result: got %h want 10505", res());
        else passes++;
    endtask

    task automatic test_mid_reset();
        logic seen = 0;
        int cyc;
        truth_table = 16'hFF00;
        start = 1;
        @(posedge clk); #1;
        start = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1;
        @(posedge clk); #1;
        rst = 0;
        checks++;
        if ({busy, done, res()} !== 19'd0) $display("FAIL mid_reset state: got %h want 0", {busy, done, res()});
        else passes++;
        repeat (20) begin
            @(posedge clk); #1;
            seen |= done | busy;
        end
        checks++;
        if (seen !== 1'b0) $display("FAIL mid_reset quiet: got %b want 0", seen);
        else passes++;
        launch(16'h0000, cyc);
        checks++;
        if ({cyc[7:0], res()} !== {8'd4, 17'h10000}) $display("FAIL mid_reset restart: got %0d %h want 4 10000", cyc, res());
        else passes++;
    endtask

    initial begin
        test_reset();
        test_case("const0", 16'h0000, {1'b1, 16'h0000}, 4);
        test_case("const1", 16'hFFFF, {1'b1, 16'h1111}, 8);
        test_case("and",    16'h8888, {1'b1, 16'h0011}, 6);
        test_case("x3",     16'hFF00, {1'b1, 16'h0505}, 14);
`ifdef ACT_C2_MAP_INV_EN
        test_case("xor",    16'h6666, {1'b0, 16'h0000}, 10);
        test_case("inv",    16'h5555, {1'b1, 16'h6600}, 16);
`else
        test_case("xor",    16'h6666, {1'b0, 16'h0000}, 6);
        test_case("inv",    16'h5555, {1'b0, 16'h0000}, 6);
`endif
        test_start_ignored();
        test_mid_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
